sensor_display: RTL and testbench
=================================

SENSOR_DISPLAY -- requirements
Module: sensor_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, giving the clk2 cycles each digit is lit.
REQ-002 SHALL have ports, clock and reset first:
- clk2  in  1  system clock for the block.
- rst  in  1  reset; asynchronous, active-high.
- hum_in  in  8  unsigned binary humidity, %RH.
- temp_in  in  8  unsigned binary temperature, degC.
- data_valid  in  1  level from the sensor reader; a new sample is marked by its rising edge.
- busy  out  1  high while a conversion is in progress.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit enables, active-low, one-hot; an[7] is the leftmost digit.
- dp  out  1  decimal point, active-low; constant 1.

Function
REQ-003 SHALL register data_valid once; a rising edge is registered 0 and current 1.
REQ-004 On a rising edge in IDLE, SHALL capture hum_in and temp_in, then enter CONV_H.
REQ-005 FSM states SHALL be IDLE, CONV_H (8 cycles), CONV_T (8 cycles), UPDATE (1 cycle), then IDLE.
REQ-006 CONV_H and CONV_T SHALL convert binary to BCD by shift-add-3: one bit per cycle, MSB first, producing hundreds, tens and units.
REQ-007 busy SHALL be 1 from the edge after capture through the UPDATE cycle, and 0 otherwise.
REQ-008 Display registers SHALL change exactly at the 17th clk2 edge after the capture edge; this is the fixed latency.
REQ-009 Rising edges while busy=1 SHALL be ignored and not queued; a held-high data_valid SHALL start only one conversion.
REQ-010 Digit layout, left to right: hum tens, hum units, blank, 'H', temp tens, temp units, degree, 'C'.
REQ-011 A tens digit of 0 SHALL be shown blank; a units digit SHALL always be shown.
REQ-012 If a value is >= 100, its tens and units digits SHALL both show '-'.
REQ-013 The refresh counter SHALL count 0..REFRESH_DIV-1; at wrap, the digit index SHALL advance modulo 8 (7 wraps to 0).
REQ-014 an SHALL drive low the bit of the current digit index; seg SHALL be the decoded code of that digit.
REQ-015 Digit codes SHALL be 0-9 numerals, 0xA 'H', 0xB 'C', 0xC degree, 0xD '-', 0xF blank.
REQ-016 Active-low seg values SHALL be: '0'=40, '1'=79, '2'=24, '3'=30, '4'=19, '5'=12, '6'=02, '7'=78, '8'=00, '9'=10, 'H'=09, 'C'=46, degree=1C, '-'=3F, blank=7F (hex).
REQ-017 Scanning SHALL continue uninterrupted during conversion.

Reset
REQ-018 While rst=1: state=IDLE, busy=0, all digit registers=blank, digit index=0, refresh counter=0, an=8'hFE, seg=7'h7F, dp=1, edge-detect register=0.
REQ-019 rst asserted mid-conversion SHALL abort it; no partial result SHALL reach the display.
REQ-020 After rst falls, the first data_valid rising edge SHALL convert normally.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding, the digit-code constants (REQ-015) and the segment table (REQ-016).
REQ-022 Decimal conversion SHALL be one sub-module, bin2bcd_seq, with ports start, 8-bit input, done and 12-bit BCD output; it SHALL be used once for humidity and once for temperature.

Verification
REQ-023 All scenarios SHALL use REFRESH_DIV=4.
REQ-024 Reset: assert rst -> an=FE, seg=7F, busy=0; after release, every digit shows blank.
REQ-025 hum=45, temp=23, data_valid rises -> 17 edges later digits read 4,5,blank,H,2,3,degree,C; seg=19 while an=7F.
REQ-026 hum=100, temp=5 -> humidity digits read '-','-' (seg 3F); temp tens blank (7F); temp units seg=12.
REQ-027 data_valid held high for 40 cycles, inputs changed at cycle 5 -> one conversion of the originally captured values; a new value is shown only after data_valid falls and rises again.
REQ-028 rst pulsed at cycle 10 of a conversion -> busy=0 at once, display blank; the next data_valid edge with hum=60, temp=30 displays 6,0,blank,H,3,0,degree,C.
REQ-029 Free-run scan -> an steps FE,FD,FB,F7,EF,DF,BF,7F with 4 cycles each, back to FE after 32 cycles.

Source files
------------

// File: rtl/sensor_display_pkg.sv
// Shared types and constants for the sensor display block:
// FSM state encoding, digit codes, segment table and digit formatting.
package sensor_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_H = 2'd1,
        ST_CONV_T = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam logic [3:0] DIG_H     = 4'hA;
    localparam logic [3:0] DIG_C     = 4'hB;
    localparam logic [3:0] DIG_DEG   = 4'hC;
    localparam logic [3:0] DIG_DASH  = 4'hD;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            DIG_H:   s = 7'h09;
            DIG_C:   s = 7'h46;
            DIG_DEG: s = 7'h1C;
            DIG_DASH: s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // {tens, units} codes from a 3-digit BCD value.
    // Values of 100 and above show dashes; a zero tens digit is blanked.
    function automatic logic [7:0] fmt_pair(input logic [11:0] b);
        logic [7:0] r;
        if (b[11:8] != 4'd0)
            r = {DIG_DASH, DIG_DASH};
        else if (b[7:4] == 4'd0)
            r = {DIG_BLANK, b[3:0]};
        else
            r = b[7:0];
        return r;
    endfunction

endpackage

// File: rtl/sensor_display_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD, shift-add-3, one bit per clock.
// Ports: clk2, rst, i_start, i_bin[7:0] -> o_done (result valid), o_bcd[11:0].
module bin2bcd_seq (
    input  logic        clk2,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic        o_done,
    output logic [11:0] o_bcd
);

    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_done;
    logic [11:0] w_adj;

    // Add 3 to any nibble >= 5 before the next shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            // First bit shifts into an all-zero BCD, so no adjust needed
            r_bcd  <= {11'd0, i_bin[7]};
            r_bin  <= {i_bin[6:0], 1'b0};
            r_cnt  <= 3'd7;
            r_done <= 1'b0;
        end else if (r_cnt != 3'd0) begin
            r_bcd  <= {w_adj[10:0], r_bin[7]};
            r_bin  <= {r_bin[6:0], 1'b0};
            r_cnt  <= r_cnt - 3'd1;
            r_done <= (r_cnt == 3'd1);
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/sensor_display.sv
// Humidity/temperature capture, BCD conversion and 8-digit multiplexed display.
// Ports: clk2, rst, hum_in, temp_in, data_valid -> busy, seg, an, dp.
module sensor_display
    import sensor_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk2,
    input  logic       rst,
    input  logic [7:0] hum_in,
    input  logic [7:0] temp_in,
    input  logic       data_valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t          r_state;
    state_t          w_state_nx;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nx;
    logic            r_dv;
    logic [7:0]      r_hum;
    logic [7:0]      r_temp;
    logic [7:0][3:0] r_dig;
    logic [RW-1:0]   r_ref;
    logic [2:0]      r_idx;

    logic            w_rise;
    logic            w_capture;
    logic            w_start_h;
    logic            w_start_t;
    logic            w_load;
    logic            w_done_h;
    logic            w_done_t;
    logic [11:0]     w_bcd_h;
    logic [11:0]     w_bcd_t;

    assign w_rise    = data_valid & ~r_dv;
    assign w_capture = (r_state == ST_IDLE) & w_rise;

    bin2bcd_seq u_bcd_h (
        .clk2    (clk2),
        .rst     (rst),
        .i_start (w_start_h),
        .i_bin   (r_hum),
        .o_done  (w_done_h),
        .o_bcd   (w_bcd_h)
    );

    bin2bcd_seq u_bcd_t (
        .clk2    (clk2),
        .rst     (rst),
        .i_start (w_start_t),
        .i_bin   (r_temp),
        .o_done  (w_done_t),
        .o_bcd   (w_bcd_t)
    );

    // Each conversion state lasts 8 cycles; the converter is
    // kicked in the first one and finishes on the state's last edge.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 3'd1;
        w_start_h  = 1'b0;
        w_start_t  = 1'b0;
        w_load     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (w_rise)
                    w_state_nx = ST_CONV_H;
            end
            ST_CONV_H: begin
                w_start_h = (r_cnt == 3'd0);
                if (r_cnt == 3'd7) begin
                    w_state_nx = ST_CONV_T;
                    w_cnt_nx   = '0;
                end
            end
            ST_CONV_T: begin
                w_start_t = (r_cnt == 3'd0);
                if (r_cnt == 3'd7) begin
                    w_state_nx = ST_UPDATE;
                    w_cnt_nx   = '0;
                end
            end
            ST_UPDATE: begin
                w_load     = w_done_h & w_done_t;
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dv    <= 1'b0;
            r_hum   <= '0;
            r_temp  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dv    <= data_valid;
            if (w_capture) begin
                r_hum  <= hum_in;
                r_temp <= temp_in;
            end
        end
    end

    // r_dig[7] is the leftmost digit
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_dig <= {8{DIG_BLANK}};
        end else if (w_load) begin
            r_dig <= {fmt_pair(w_bcd_h), DIG_BLANK, DIG_H,
                      fmt_pair(w_bcd_t), DIG_DEG, DIG_C};
        end
    end

    // Scan runs independently of the conversion FSM
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign an   = ~(8'd1 << r_idx);
    assign seg  = seg_decode(r_dig[r_idx]);
    assign dp   = 1'b1;

endmodule

// File: tb/tb_sensor_display.sv
// Randomized bench for sensor_display with a cycle-count reference model.
// Every negedge compares an/seg/busy/dp with the model's expectation.
module tb_sensor_display;

    logic       clk2;
    logic       rst;
    logic [7:0] hum_in;
    logic [7:0] temp_in;
    logic       data_valid;
    logic       busy;
    logic [6:0] seg;
    logic [7:0] an;
    logic       dp;

    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 0;

    sensor_display #(.REFRESH_DIV(4)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .hum_in     (hum_in),
        .temp_in    (temp_in),
        .data_valid (data_valid),
        .busy       (busy),
        .seg        (seg),
        .an         (an),
        .dp         (dp)
    );

    initial begin
        clk2 = 0;
        forever #5 clk2 = ~clk2;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Segment codes, index = digit code (0xE unused -> blank)
    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h09, 7'h46, 7'h1C, 7'h3F, 7'h7F, 7'h7F
    };

    // Reference model: a conversion is 17 edges of latency counted from
    // the capturing edge; the display then shows the captured values.
    int         m_ticks;
    int         m_left;
    logic       m_prev_dv;
    int         m_h;
    int         m_t;
    logic [3:0] m_dig [8];

    function automatic logic [3:0] tens_of(input int v);
        if (v >= 100) return 4'hD;
        if (v / 10 == 0) return 4'hF;
        return 4'(v / 10);
    endfunction

    function automatic logic [3:0] units_of(input int v);
        if (v >= 100) return 4'hD;
        return 4'(v % 10);
    endfunction

    always @(posedge clk2 or posedge rst) begin
        if (rst) begin
            m_ticks   = 0;
            m_left    = 0;
            m_prev_dv = 0;
            for (int i = 0; i < 8; i++) m_dig[i] = 4'hF;
        end else begin
            m_ticks++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_dig[7] = tens_of(m_h);
                    m_dig[6] = units_of(m_h);
                    m_dig[5] = 4'hF;
                    m_dig[4] = 4'hA;
                    m_dig[3] = tens_of(m_t);
                    m_dig[2] = units_of(m_t);
                    m_dig[1] = 4'hC;
                    m_dig[0] = 4'hB;
                end
            end else if (data_valid && !m_prev_dv) begin
                m_h    = int'(hum_in);
                m_t    = int'(temp_in);
                m_left = 17;
            end
            m_prev_dv = data_valid;
        end
    end

    always @(negedge clk2) begin
        if (mon_en) begin
            int         idx;
            logic [7:0] e_an;
            logic [6:0] e_seg;
            idx   = (m_ticks / 4) % 8;
            e_an  = ~(8'd1 << idx);
            e_seg = seg_tab[m_dig[idx]];
            chk("an", 32'(an), 32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("dp", 32'(dp), 32'd1);
        end
    end

    task automatic tick();
        @(negedge clk2);
    endtask

    task automatic conv(input int h, input int t);
        tick();
        hum_in     = 8'(h);
        temp_in    = 8'(t);
        data_valid = 1;
        repeat (2) tick();
        data_valid = 0;
        repeat (24) tick();
    endtask

    // Wait (bounded) for digit position pos to be lit, then check its seg
    task automatic digit_is(input string tag, input int pos,
                            input logic [6:0] exp);
        logic [7:0] want;
        bit         hit;
        want = ~(8'd1 << pos);
        hit  = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (an == want) hit = 1;
        end
        if (hit) chk(tag, 32'(seg), 32'(exp));
        else     chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst        = 1;
        data_valid = 0;
        hum_in     = 0;
        temp_in    = 0;
        repeat (3) tick();
        chk("rst_an", 32'(an), 32'hFE);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        mon_en = 1;
        #2 rst = 0;

        // Free-run scan with blank digits
        repeat (34) tick();

        conv(45, 23);
        digit_is("h45_tens", 7, 7'h19);
        digit_is("h45_units", 6, 7'h12);
        digit_is("t23_deg", 1, 7'h1C);

        conv(100, 5);
        digit_is("h100_tens", 7, 7'h3F);
        digit_is("h100_units", 6, 7'h3F);
        digit_is("t5_tens", 3, 7'h7F);
        digit_is("t5_units", 2, 7'h12);

        // Held-high data_valid, inputs change mid-hold
        tick();
        hum_in     = 10;
        temp_in    = 11;
        data_valid = 1;
        repeat (5) tick();
        hum_in  = 77;
        temp_in = 88;
        repeat (35) tick();
        digit_is("held_h_tens", 7, 7'h79);
        data_valid = 0;
        repeat (3) tick();
        data_valid = 1;
        repeat (2) tick();
        data_valid = 0;
        repeat (20) tick();
        digit_is("held_new", 7, 7'h78);

        // Reset mid-conversion
        hum_in     = 99;
        temp_in    = 99;
        data_valid = 1;
        tick();
        data_valid = 0;
        repeat (9) tick();
        #2 rst = 1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        #2 rst = 0;
        conv(60, 30);
        digit_is("h60_tens", 7, 7'h02);
        digit_is("t30_units", 2, 7'h40);

        // Random traffic, including edges while busy and reset pulses
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) data_valid = ~data_valid;
            hum_in  = 8'($urandom);
            temp_in = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1;
                tick();
                #2 rst = 0;
            end
        end
        data_valid = 0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
